seq_pattern_tx: RTL and testbench
=================================

Name: seq_pattern_tx

Overview:
Serial pattern transmitter: on request, drives a programmable PAT_W-bit pattern MSB-first onto a single-bit serial line (p1_out), repeated a programmable number of times with optional idle gaps between repetitions. It is the generator side of the lab's serial sequence detectors. It supplies stimulus such as 1100 to a downstream Moore detector, and exercises the start/busy/done handshake used across the FSM blocks.

Parameters:
PAT_W, 4, pattern width in bits (>=2)
REP_W, 4, width of repetition count input
GAP_CYCLES, 2, idle cycles (p1_out=0, bit_valid=0) between consecutive repetitions; 0 = back-to-back

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
pattern  input  PAT_W  pattern to send, bit PAT_W-1 sent first; captured with start
reps  input  REP_W  number of repetitions; captured with start
abort  input  1  terminates transmission in SHIFT/GAP
p1_out  output  1  serial data line, registered
bit_valid  output  1  high while p1_out carries a pattern bit, registered
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse on normal completion

Behaviour:
- Reset: rst=1 at a clock edge -> state IDLE, p1_out=0, bit_valid=0, busy=0, done=0, shift reg=0, counters=0. Reset overrides start/abort and takes effect mid-transmission with no done pulse.
- All outputs are Moore: decoded from registered state/shift register only, never from inputs combinationally.
- States: IDLE, SHIFT, GAP, DONE. Encoding is in the package.
- IDLE:
  - start=1 and reps!=0 -> capture pattern into shift reg, rem_reps=reps, bit_cnt=0, go SHIFT.
  - start=1 and reps==0 -> go DONE. No bits are emitted.
  - start=0 -> stay.
- SHIFT:
  - Outputs: p1_out=shreg[PAT_W-1], bit_valid=1. Shift left by one per cycle; bit_cnt increments.
  - On the last bit (bit_cnt==PAT_W-1), decrement rem_reps, then:
    - rem_reps==1 -> DONE.
    - else GAP_CYCLES>0 -> GAP.
    - else reload shreg from captured pattern and stay in SHIFT with bit_cnt=0. No bubble.
- GAP: p1_out=0, bit_valid=0 for exactly GAP_CYCLES cycles, then reload shreg and go SHIFT.
- DONE: done=1, busy=1, p1_out=0, for one cycle. Then IDLE.
- Latency: start sampled at edge k -> first bit visible cycle k+1.
  - Bits of rep r (r=0..reps-1) occupy cycles k+1+r*(PAT_W+GAP_CYCLES) .. +PAT_W-1.
  - done is high in the cycle after the last bit.
- start outside IDLE is ignored. The captured pattern/reps are stable during a transmission; input changes do not affect it.
- abort=1 in SHIFT or GAP -> next cycle IDLE, p1_out=0, bit_valid=0, no done pulse. abort in IDLE or DONE is ignored.
- abort and start together in IDLE -> start wins; abort is not evaluated in IDLE.
- Counters: bit_cnt width $clog2(PAT_W), gap_cnt width $clog2(GAP_CYCLES+1) (min 1), rem_reps width REP_W. reps at max value (2^REP_W-1) must transmit fully with no wrap.
- Next-state logic has a default arm: unreachable encodings go to IDLE.

Decomposition:
- Package seq_tx_pkg: state encoding constants (IDLE, SHIFT, GAP, DONE) and state width.
- Single module. The shift register/bit counter may be split into sub-module pattern_shreg (load, shift, msb, last_bit), but this is not required.

Test Plan:
- Reset mid-run: start pattern=1100 reps=3, assert rst during the 2nd bit -> next cycle p1_out=0, busy=0, bit_valid=0; done never pulses.
- Basic: PAT_W=4, GAP=2, start pattern=1100 reps=1 at edge k -> p1_out=1,1,0,0 on cycles k+1..k+4, bit_valid=1 on those cycles; done=1 at k+5; busy low at k+6.
- Repeat with gap: pattern=1011 reps=2 GAP=2 -> 1011, 0 0 (bit_valid=0), 1011, then done. 11 cycles from k+1 to done inclusive.
- Back-to-back (GAP_CYCLES=0 build): pattern=1100 reps=3 -> 12 contiguous valid bits 110011001100, bit_valid never drops, done at k+13.
- reps=0 and ignored start: start reps=0 -> done at k+1, bit_valid never high. Pulse start during SHIFT of a reps=2 transmission -> transmission unchanged, one done only.
- Abort: pattern=1111 reps=5, abort on the 3rd bit cycle -> IDLE next cycle, p1_out=0, no done. A new start afterward transmits normally.

Source files
------------

// File: rtl/seq_tx_pkg.sv
// Shared definitions for the serial pattern transmitter.
// State encoding is fixed here so checkers can decode the state register.
package seq_tx_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a captured PAT_W-bit pattern MSB-first,
// repeated a captured number of times, with optional idle gaps between reps.
module seq_pattern_tx
  import seq_tx_pkg::*;
#(
  parameter int PAT_W      = 4,
  parameter int REP_W      = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [REP_W-1:0] reps,
  input  logic             abort,
  output logic             p1_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(PAT_W);
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(PAT_W - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  // Handshake: start is accepted only while busy=0 (IDLE); once accepted,
  // busy stays high until the cycle after the one-cycle done pulse, or until
  // an abort returns the block to IDLE without a done pulse.

  tx_state_t        state, state_n;
  logic [PAT_W-1:0] shreg, shreg_n;
  logic [PAT_W-1:0] pat_q, pat_q_n;
  logic [REP_W-1:0] rem_reps, rem_reps_n;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_n;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_n;

  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    pat_q_n    = pat_q;
    rem_reps_n = rem_reps;
    bit_cnt_n  = bit_cnt;
    gap_cnt_n  = gap_cnt;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (reps != '0) begin
            pat_q_n    = pattern;
            shreg_n    = pattern;
            rem_reps_n = reps;
            bit_cnt_n  = '0;
            state_n    = ST_SHIFT;
          end else begin
            state_n = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_n = ST_IDLE;
        end else begin
          shreg_n   = {shreg[PAT_W-2:0], 1'b0};
          bit_cnt_n = bit_cnt + 1'b1;
          if (bit_cnt == BIT_LAST) begin
            // rem_reps still holds the count including the rep just finished
            rem_reps_n = rem_reps - 1'b1;
            bit_cnt_n  = '0;
            if (rem_reps == REP_W'(1)) begin
              state_n = ST_DONE;
            end else if (GAP_CYCLES > 0) begin
              gap_cnt_n = '0;
              state_n   = ST_GAP;
            end else begin
              shreg_n = pat_q;
            end
          end
        end
      end
      ST_GAP: begin
        if (abort) begin
          state_n = ST_IDLE;
        end else if (gap_cnt == GAP_LAST) begin
          shreg_n   = pat_q;
          bit_cnt_n = '0;
          gap_cnt_n = '0;
          state_n   = ST_SHIFT;
        end else begin
          gap_cnt_n = gap_cnt + 1'b1;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Outputs are flopped from the next state so they align with the state
  // register: the first bit appears in the cycle right after start is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      pat_q     <= '0;
      rem_reps  <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      p1_out    <= 1'b0;
      bit_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      pat_q     <= pat_q_n;
      rem_reps  <= rem_reps_n;
      bit_cnt   <= bit_cnt_n;
      gap_cnt   <= gap_cnt_n;
      p1_out    <= (state_n == ST_SHIFT) & shreg_n[PAT_W-1];
      bit_valid <= (state_n == ST_SHIFT);
      busy      <= (state_n != ST_IDLE);
      done      <= (state_n == ST_DONE);
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: a gapped build (GAP_CYCLES=2) and a
// back-to-back build (GAP_CYCLES=0) share stimulus; expected output words are queued per cycle.
module tb_seq_pattern_tx;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] pattern;
  logic [3:0] reps;
  logic       abort;

  logic p1_a, valid_a, busy_a, done_a;
  logic p1_b, valid_b, busy_b, done_b;

  always #5 clk = ~clk;

  seq_pattern_tx #(.PAT_W(4), .REP_W(4), .GAP_CYCLES(2)) u_gap (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .reps(reps),
    .abort(abort), .p1_out(p1_a), .bit_valid(valid_a), .busy(busy_a), .done(done_a)
  );

  seq_pattern_tx #(.PAT_W(4), .REP_W(4), .GAP_CYCLES(0)) u_b2b (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .reps(reps),
    .abort(abort), .p1_out(p1_b), .bit_valid(valid_b), .busy(busy_b), .done(done_b)
  );

  // ---------------- scoreboard ----------------
  // Each entry is {busy, done, bit_valid, p1_out} for one cycle.
  logic [3:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b (busy,done,valid,p1)", tag, obs, exp);
    end
  endtask

  task automatic push_rep(input logic [3:0] pat);
    for (int i = 3; i >= 0; i--) exp_q.push_back({3'b101, pat[i]});
  endtask

  task automatic push_word(input logic [3:0] w, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(w);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic do_start(input logic [3:0] pat, input logic [3:0] n, input logic ab);
    start   = 1'b1;
    pattern = pat;
    reps    = n;
    abort   = ab;
    tick();
    start = 1'b0;
    abort = 1'b0;
  endtask

  // Drain the queue one cycle per entry; poke_kind 1=stray start, 2=abort, 3=rst
  // applied during entry poke_at so it is sampled at the following edge.
  task automatic run_q(input bit use_b2b, input string tag, input int poke_at, input int poke_kind);
    logic [3:0] e, obs;
    int idx;
    idx = 0;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      obs = use_b2b ? {busy_b, done_b, valid_b, p1_b} : {busy_a, done_a, valid_a, p1_a};
      chk(tag, obs, e);
      if (idx == poke_at) begin
        case (poke_kind)
          1: begin start = 1'b1; pattern = 4'b0101; reps = 4'd7; end
          2: abort = 1'b1;
          3: rst = 1'b1;
          default: ;
        endcase
      end
      tick();
      start = 1'b0;
      abort = 1'b0;
      rst   = 1'b0;
      idx++;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; pattern = '0; reps = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_gap", {busy_a, done_a, valid_a, p1_a}, 4'b0000);
    chk("reset_b2b", {busy_b, done_b, valid_b, p1_b}, 4'b0000);

    // Basic single rep, with abort asserted alongside start (start wins in IDLE)
    do_start(4'b1100, 4'd1, 1'b1);
    push_rep(4'b1100); push_word(4'b1100, 1); push_word(4'b0000, 2);
    run_q(1'b0, "basic_1100", -1, 0);

    // Two reps with a two-cycle gap
    do_start(4'b1011, 4'd2, 1'b0);
    push_rep(4'b1011); push_word(4'b1000, 2); push_rep(4'b1011);
    push_word(4'b1100, 1); push_word(4'b0000, 2);
    run_q(1'b0, "gap_1011", -1, 0);

    // Back-to-back build: 12 contiguous valid bits, done at k+13
    do_reset();
    do_start(4'b1100, 4'd3, 1'b0);
    push_rep(4'b1100); push_rep(4'b1100); push_rep(4'b1100);
    push_word(4'b1100, 1); push_word(4'b0000, 2);
    run_q(1'b1, "b2b_1100", -1, 0);
    do_reset();

    // reps=0: immediate done, no bits
    do_start(4'b1111, 4'd0, 1'b0);
    push_word(4'b1100, 1); push_word(4'b0000, 2);
    run_q(1'b0, "reps_zero", -1, 0);

    // Stray start during SHIFT is ignored
    do_start(4'b1001, 4'd2, 1'b0);
    push_rep(4'b1001); push_word(4'b1000, 2); push_rep(4'b1001);
    push_word(4'b1100, 1); push_word(4'b0000, 3);
    run_q(1'b0, "stray_start", 1, 1);

    // Abort on the 3rd bit: idle next cycle, no done
    do_start(4'b1111, 4'd5, 1'b0);
    push_word(4'b1011, 3); push_word(4'b0000, 4);
    run_q(1'b0, "abort", 2, 2);

    // Fresh start after abort transmits normally
    do_start(4'b0110, 4'd1, 1'b0);
    push_rep(4'b0110); push_word(4'b1100, 1); push_word(4'b0000, 1);
    run_q(1'b0, "after_abort", -1, 0);

    // Reset during the 2nd bit: outputs clear, done never pulses
    do_start(4'b1100, 4'd3, 1'b0);
    push_word(4'b1011, 2); push_word(4'b0000, 6);
    run_q(1'b0, "reset_mid", 1, 3);

    // Maximum repetition count transmits all 15 reps without wrap
    do_start(4'b1001, 4'd15, 1'b0);
    for (int r = 0; r < 15; r++) begin
      push_rep(4'b1001);
      if (r != 14) push_word(4'b1000, 2);
    end
    push_word(4'b1100, 1); push_word(4'b0000, 2);
    run_q(1'b0, "reps_max", -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
